// File: rtl/gate_test_sequencer.sv
// Clocked stimulus/check sequencer for parallel 2-input NAND gates.
// Steps a/b through 00,01,10,11 and scores every gate output per pattern.
module gate_test_sequencer #(
  parameter int NUM_DUT = 4,
  parameter int SETTLE  = 2,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NUM_DUT-1:0] y,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_DUT-1:0] err_mask,
  output logic [CNT_W-1:0]   err_count
);

  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PW   = $clog2(NUM_DUT + 1);
  localparam int SW   = CNT_W + PW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [1:0]        pat_q;
  logic [1:0]        pat_nxt;
  logic [SC_W-1:0]   cnt_q;
  logic              settled;
  logic              exp_y;
  logic [NUM_DUT-1:0] mism;
  logic [NUM_DUT-1:0] mask_nxt;
  logic [PW-1:0]     n_mis;
  logic [SW-1:0]     sum;
  logic [CNT_W-1:0]  cnt_sat;

  assign settled  = (cnt_q == SC_W'(SETTLE - 1));
  assign pat_nxt  = pat_q + 2'd1;
  assign mask_nxt = err_mask | mism;

  // X/Z on y must score as a failure, hence the case inequality
  always_comb begin
    exp_y = ~(a & b);
    mism  = '0;
    n_mis = '0;
    for (int i = 0; i < NUM_DUT; i++) begin
      mism[i] = (y[i] !== exp_y);
      n_mis   = n_mis + PW'(mism[i]);
    end
    sum     = SW'(err_count) + SW'(n_mis);
    cnt_sat = (sum > SW'({CNT_W{1'b1}})) ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_DRIVE;
      S_DRIVE:  if (settled) state_d = S_SAMPLE;
      S_SAMPLE: state_d = (pat_q == 2'd3) ? S_DONE : S_DRIVE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    done = (state_q == S_DONE);
  end

  // pass is resolved on entry to DONE so it is valid alongside done
  always_ff @(posedge clk) begin
    if (rst) begin
      a         <= 1'b0;
      b         <= 1'b0;
      pass      <= 1'b0;
      err_mask  <= '0;
      err_count <= '0;
      pat_q     <= 2'd0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          a <= 1'b0;
          b <= 1'b0;
          if (start) begin
            err_mask  <= '0;
            err_count <= '0;
            pass      <= 1'b0;
            pat_q     <= 2'd0;
            cnt_q     <= '0;
          end
        end
        S_DRIVE: begin
          cnt_q <= settled ? '0 : cnt_q + SC_W'(1);
        end
        S_SAMPLE: begin
          err_mask  <= mask_nxt;
          err_count <= cnt_sat;
          if (pat_q == 2'd3) begin
            a    <= 1'b0;
            b    <= 1'b0;
            pass <= (mask_nxt == '0);
          end else begin
            pat_q <= pat_nxt;
            a     <= pat_nxt[1];
            b     <= pat_nxt[0];
          end
        end
        S_DONE: begin
          a <= 1'b0;
          b <= 1'b0;
        end
      endcase
    end
  end

endmodule
